shared_data_stream_encoder: RTL

//  - TX end of the shared-data link. Accepts AXI4-Lite writes from the local shared-memory master and queues them.
//  - Serialises each write into one framed 16-bit 8b10b-symbol stream (xcvr_tx_data_word_t) toward the transceiver.
//  - Fills idle time with K28.5 commas; paced by the TX-slot enable; the far-end stream decoder turns frames back into writes.

---
 rtl/shared_data_link_pkg.sv | 47 ++++
 rtl/axi4_lite_if.sv | 33 +++
 rtl/shared_data_tx_fifo.sv | 59 +++++
 rtl/shared_data_stream_encoder.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/shared_data_link_pkg.sv
// Shared-data link definitions common to the TX stream encoder and the far-end decoder.
// Frame symbols, transceiver word type, frame FSM encoding, queued entry and CRC-8 step.
package shared_data_link_pkg;

    localparam int SHARED_MEM_AW = 12;
    localparam int LLRF_DW       = 32;

    localparam logic [7:0] K_COMMA = 8'hBC;
    localparam logic [7:0] K_SOF   = 8'hFB;
    localparam logic [7:0] K_EOF   = 8'hFD;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef struct packed {
        logic [15:0] data;
        logic [1:0]  iskey;
    } xcvr_tx_data_word_t;

    localparam xcvr_tx_data_word_t IDLE_WORD = '{data: {K_COMMA, K_COMMA}, iskey: 2'b11};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SOF,
        ST_ADDR,
        ST_DHI,
        ST_DLO,
        ST_EOF,
        ST_GAP
    } frame_state_t;

    typedef struct packed {
        logic [15:0] addr;
        logic [31:0] data;
    } tx_entry_t;

    // CRC-8, polynomial 0x07, one byte per call, MSB first.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] din);
        logic [7:0] c;
        c = crc ^ din;
        for (int unsigned i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/axi4_lite_if.sv
// AXI4-Lite bundle shared by the local shared-memory master and the link endpoints.
interface axi4_lite_if #(
    parameter int AW = 16,
    parameter int DW = 32
);
    logic [AW-1:0]   awaddr;
    logic            awvalid;
    logic            awready;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            wvalid;
    logic            wready;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;
    logic [AW-1:0]   araddr;
    logic            arvalid;
    logic            arready;
    logic [DW-1:0]   rdata;
    logic [1:0]      rresp;
    logic            rvalid;
    logic            rready;

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/shared_data_tx_fifo.sv
// First-word-fall-through queue of pending link writes; rd_data is valid whenever !empty.
module shared_data_tx_fifo
    import shared_data_link_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  tx_entry_t wr_data,
    input  logic      pop,
    output tx_entry_t rd_data,
    output logic      full,
    output logic      empty
);

    localparam int PW = $clog2(DEPTH);

    tx_entry_t       mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW:0]     count;
    logic            do_push;
    logic            do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push against a full queue still lands.
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/shared_data_stream_encoder.sv
// TX end of the shared-data link: queues AXI4-Lite writes and frames them as 8b10b symbol words.
// Build option SHARED_DATA_TX_CRC_EN replaces the constant EOF check byte with a CRC-8.
module shared_data_stream_encoder
    import shared_data_link_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int AW         = SHARED_MEM_AW,
    parameter int DW         = LLRF_DW
) (
    input  logic               clk,
    input  logic               rst,
    axi4_lite_if.slave         s_axi,
    input  logic               data_tx_ena,
    output logic               data_tx_req,
    output xcvr_tx_data_word_t tx_data_out
);

    logic          aw_held;
    logic          w_held;
    logic [AW-1:0] aw_addr_q;
    logic [DW-1:0] w_data_q;
    logic [3:0]    w_strb_q;
    logic          bvalid_q;
    logic [1:0]    bresp_q;
    logic          rvalid_q;

    logic          resp_stall;
    logic          aw_fire;
    logic          w_fire;
    logic          commit;

    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    tx_entry_t     fifo_wr;
    tx_entry_t     fifo_rd;

    frame_state_t  state_q;
    frame_state_t  state_d;
    tx_entry_t     entry_q;
    logic [7:0]    seq_q;
    logic [7:0]    chk;

    logic          unused_ar;

    // Write path: independent AW/W capture, one write in flight, one outstanding response.
    assign resp_stall    = bvalid_q && !s_axi.bready;
    assign s_axi.awready = !aw_held && !fifo_full && !resp_stall;
    assign s_axi.wready  = !w_held && !fifo_full && !resp_stall;
    assign aw_fire       = s_axi.awvalid && s_axi.awready;
    assign w_fire        = s_axi.wvalid && s_axi.wready;
    assign commit        = aw_held && w_held;
    assign fifo_push     = commit && (w_strb_q == 4'hF);
    assign fifo_wr       = '{addr: 16'(aw_addr_q), data: w_data_q};
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bresp   = bresp_q;

    assign s_axi.arready = 1'b1;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rresp   = AXI_RESP_SLVERR;
    assign s_axi.rdata   = '0;
    assign unused_ar     = ^s_axi.araddr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= AXI_RESP_OKAY;
            rvalid_q  <= 1'b0;
        end else begin
            if (aw_fire) begin
                aw_held   <= 1'b1;
                aw_addr_q <= s_axi.awaddr;
            end else if (commit) begin
                aw_held <= 1'b0;
            end
            if (w_fire) begin
                w_held   <= 1'b1;
                w_data_q <= s_axi.wdata;
                w_strb_q <= s_axi.wstrb;
            end else if (commit) begin
                w_held <= 1'b0;
            end
            if (commit) begin
                bvalid_q <= 1'b1;
                bresp_q  <= fifo_push ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
            end else if (s_axi.bready) begin
                bvalid_q <= 1'b0;
            end
            if (s_axi.arvalid && !rvalid_q) begin
                rvalid_q <= 1'b1;
            end else if (s_axi.rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    shared_data_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (fifo_push),
        .wr_data (fifo_wr),
        .pop     (fifo_pop),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // The next frame's entry is taken on the same ena cycle that moves into SOF.
    assign fifo_pop = data_tx_ena && !fifo_empty && ((state_q == ST_IDLE) || (state_q == ST_GAP));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (data_tx_ena) begin
            case (state_q)
                ST_IDLE: state_d = fifo_empty ? ST_IDLE : ST_SOF;
                ST_SOF:  state_d = ST_ADDR;
                ST_ADDR: state_d = ST_DHI;
                ST_DHI:  state_d = ST_DLO;
                ST_DLO:  state_d = ST_EOF;
                ST_EOF:  state_d = ST_GAP;
                ST_GAP:  state_d = fifo_empty ? ST_IDLE : ST_SOF;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        tx_data_out = IDLE_WORD;
        data_tx_req = !fifo_empty || (state_q != ST_IDLE);
        case (state_q)
            ST_SOF:  tx_data_out = '{data: {K_SOF, seq_q}, iskey: 2'b10};
            ST_ADDR: tx_data_out = '{data: entry_q.addr, iskey: 2'b00};
            ST_DHI:  tx_data_out = '{data: entry_q.data[31:16], iskey: 2'b00};
            ST_DLO:  tx_data_out = '{data: entry_q.data[15:0], iskey: 2'b00};
            ST_EOF:  tx_data_out = '{data: {K_EOF, chk}, iskey: 2'b10};
            default: tx_data_out = IDLE_WORD;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            entry_q <= '0;
            seq_q   <= '0;
        end else begin
            if (fifo_pop) begin
                entry_q <= fifo_rd;
            end
            if (data_tx_ena && (state_q == ST_EOF)) begin
                seq_q <= seq_q + 8'd1;
            end
        end
    end

`ifdef SHARED_DATA_TX_CRC_EN
    logic [7:0] crc_q;

    // Seq byte is folded in with the address so each frame restarts from a clean CRC.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            crc_q <= '0;
        end else if (data_tx_ena) begin
            case (state_q)
                ST_ADDR: crc_q <= crc8_step(crc8_step(crc8_step(8'h00, seq_q),
                                                      entry_q.addr[15:8]), entry_q.addr[7:0]);
                ST_DHI:  crc_q <= crc8_step(crc8_step(crc_q, entry_q.data[31:24]), entry_q.data[23:16]);
                ST_DLO:  crc_q <= crc8_step(crc8_step(crc_q, entry_q.data[15:8]), entry_q.data[7:0]);
                default: crc_q <= crc_q;
            endcase
        end
    end

    assign chk = crc_q;
`else
    assign chk = 8'h00;
`endif

endmodule
